// File: rtl/serial_word_collector.sv
// Assembles an LSB-first serial bit stream into WIDTH-bit words and queues them in a DEPTH-entry FIFO.
// Define COLLECTOR_PARITY_EN to add a trailing even-parity bit per frame and report the result per word.
module serial_word_collector #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     flush,
  output logic [WIDTH-1:0]         word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     parity_err,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef COLLECTOR_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

`ifdef COLLECTOR_PARITY_EN
  typedef enum logic { COLLECT, PARITY } state_t;
`else
  typedef enum logic { COLLECT } state_t;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic              push;
  logic [EW-1:0]     push_entry;

  // ---------------------------------------------------------------------------
  // Deserializer: state register and next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the combinational process below uses blocking ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    push       = 1'b0;
    push_entry = '0;
    if (flush) begin
      state_d = COLLECT;
      cnt_d   = '0;
    end else if (bit_valid) begin
      unique case (state_q)
        COLLECT: begin
          shift_d[cnt_q] = bit_in;
          if (cnt_q == CW'(WIDTH - 1)) begin
            cnt_d = '0;
`ifdef COLLECTOR_PARITY_EN
            state_d = PARITY;
`else
            push       = 1'b1;
            push_entry = shift_d;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef COLLECTOR_PARITY_EN
        PARITY: begin
          // Even parity over data plus parity bit; a 1 means the frame is bad.
          push       = 1'b1;
          push_entry = {^{shift_q, bit_in}, shift_q};
          state_d    = COLLECT;
        end
`endif
        default: state_d = COLLECT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          pop, full, do_push, drop;
  logic [EW-1:0] head;

  assign word_valid = (level != '0);
  assign full       = (level == LW'(DEPTH));
  assign pop        = word_valid & word_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_push    = push & (~full | pop);
  assign drop       = push & full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        level  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        unique case ({do_push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; stale entries are never observable
  // because the outputs are gated by word_valid, which comes from level.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head     = mem[rd_ptr];
  assign word_out = word_valid ? head[WIDTH-1:0] : '0;
`ifdef COLLECTOR_PARITY_EN
  assign parity_err = word_valid & head[WIDTH];
`else
  assign parity_err = 1'b0;
`endif

endmodule
